imem_boot_loader: RTL and testbench

- Sequences runtime (re)loading of the byte-addressed, 1024-cell instruction memory from an external byte stream, such as a UART receiver.
- Holds the 5-stage pipeline while loading. It writes bytes big-endian in word order: cell 4k holds the MSB of word k.
- Validates the stream with a length header and an 8-bit checksum, then releases the pipeline with a one-cycle restart pulse.
- Sits between the boot byte source, the instruction memory write port, and the hazard/stall logic of the IF stage.

---
 rtl/imem_boot_loader_pkg.sv | 30 +++
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants, loader state encoding and header validation for the
// instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned INSTR_MEM_SIZE = 1024;
  localparam int unsigned ADDR_W         = $clog2(INSTR_MEM_SIZE);
  localparam int unsigned WORD_LEN       = 32;
  localparam int unsigned MEM_CELL_SIZE  = 8;
  localparam int unsigned CELL_W         = MEM_CELL_SIZE;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned CNT_W          = ADDR_W + 1;

  localparam logic [WORD_LEN-1:0] NOP = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LOAD   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // A usable image is non-empty, fits in memory and is whole words.
  function automatic logic len_ok(input logic [LEN_W-1:0] n);
    return (n != '0) && (n <= LEN_W'(INSTR_MEM_SIZE)) && (n[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot byte stream plus instruction-memory byte write port.
interface imem_boot_loader_if;
  import imem_boot_loader_pkg::*;

  logic [CELL_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CELL_W-1:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/imem_boot_loader.sv
// Reloads instruction memory from a length-prefixed, checksummed byte stream
// while holding the pipeline, then restarts it from PC 0.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.master  bus,
  input  logic [WORD_LEN-1:0] mem_instr,
  output logic [WORD_LEN-1:0] fetch_instr,
  output logic                cpu_hold,
  output logic                cpu_restart,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [CELL_W-1:0] sum_q, sum_d;

  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [CELL_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_restart_q, cpu_restart_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rx_fire;
  logic [LEN_W-1:0]  len_full;
  logic [CELL_W-1:0] sum_next;

  assign rx_fire  = bus.rx_valid && rx_ready_q;
  assign len_full = {len_q[LEN_W-1:CELL_W], bus.rx_data};
  // Checksum covers the length header as well as the payload.
  assign sum_next = sum_q + bus.rx_data;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    byte_cnt_d    = byte_cnt_q;
    addr_cnt_d    = addr_cnt_q;
    sum_d         = sum_q;
    mem_we_d      = 1'b0;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_hold_d    = cpu_hold_q;
    cpu_restart_d = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
          addr_cnt_d = '0;
          sum_d      = '0;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      ST_LEN_HI: begin
        if (rx_fire) begin
          len_d[LEN_W-1:CELL_W] = bus.rx_data;
          sum_d                 = sum_next;
          state_d               = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (rx_fire) begin
          len_d = len_full;
          sum_d = sum_next;
          if (len_ok(len_full)) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      // Each accepted byte is written the following cycle at the running address.
      ST_LOAD: begin
        if (rx_fire) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = addr_cnt_q;
          mem_wdata_d = bus.rx_data;
          addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
          byte_cnt_d  = byte_cnt_q + CNT_W'(1);
          sum_d       = sum_next;
          if (LEN_W'(byte_cnt_q) + LEN_W'(1) == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end

      // On failure cpu_hold stays high so a partial image never executes.
      ST_CSUM: begin
        if (rx_fire) begin
          busy_d = 1'b0;
          if (bus.rx_data == sum_q) begin
            state_d       = ST_DONE;
            done_d        = 1'b1;
            cpu_hold_d    = 1'b0;
            cpu_restart_d = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                 (state_d == ST_LOAD)   || (state_d == ST_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      byte_cnt_q    <= '0;
      addr_cnt_q    <= '0;
      sum_q         <= '0;
      rx_ready_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      cpu_hold_q    <= 1'b0;
      cpu_restart_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      byte_cnt_q    <= byte_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      sum_q         <= sum_d;
      rx_ready_q    <= rx_ready_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_hold_q    <= cpu_hold_d;
      cpu_restart_q <= cpu_restart_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign cpu_restart   = cpu_restart_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  // Feed NOPs to IF while the image is being replaced or is invalid.
  assign fetch_instr = cpu_hold_q ? NOP : mem_instr;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good loads, gapped stream, bad headers,
// bad checksum, ignored start and mid-load reset.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [WORD_LEN-1:0] mem_instr;
  logic [WORD_LEN-1:0] fetch_instr;
  logic                cpu_hold, cpu_restart, busy, done, err;

  imem_boot_loader_if bif ();

  imem_boot_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bif.master),
    .mem_instr   (mem_instr),
    .fetch_instr (fetch_instr),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] pl [8];
  logic [ADDR_W-1:0] wr_a [$];
  logic [7:0]        wr_d [$];
  int   lat_bad   = 0;
  int   fetch_bad = 0;
  int   restart_n = 0;
  logic prev_acc  = 1'b0;
  logic [7:0] prev_dat = 8'h0;

  // Records writes (pre-edge values) and checks each follows an acceptance by one cycle.
  always @(posedge clk) begin
    if (bif.mem_we) begin
      wr_a.push_back(bif.mem_waddr);
      wr_d.push_back(bif.mem_wdata);
      if (!(prev_acc && prev_dat == bif.mem_wdata)) lat_bad <= lat_bad + 1;
    end
    if (cpu_hold && fetch_instr != 32'h0) fetch_bad <= fetch_bad + 1;
    if (cpu_restart) restart_n <= restart_n + 1;
    prev_acc <= bif.rx_valid && bif.rx_ready;
    prev_dat <= bif.rx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (bif.rx_ready) ok = 1'b1;
      @(negedge clk);
    end
    bif.rx_valid = 1'b0;
    check("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_stream(input int gap, input logic [7:0] csum);
    send_byte(8'h00, gap);
    send_byte(8'h08, gap);
    for (int i = 0; i < 8; i++) send_byte(pl[i], gap);
    send_byte(csum, gap);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 32'(wr_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_waddr"}, (i < wr_a.size()) ? 32'(wr_a[i]) : 32'hFFFF_FFFF, 32'(i));
      check({tag, "_wdata"}, (i < wr_d.size()) ? 32'(wr_d[i]) : 32'hFFFF_FFFF, 32'(pl[i]));
    end
    check({tag, "_latency"}, 32'(lat_bad), 32'd0);
  endtask

  task automatic bad_header(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    wr_a.delete(); wr_d.delete();
    pulse_start();
    send_byte(hi, 0);
    send_byte(lo, 0);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rx_ready"}, 32'(bif.rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_no_write"}, 32'(wr_a.size()), 32'd0);
  endtask

  initial begin
    int rn;
    pl[0] = 8'h80; pl[1] = 8'h20; pl[2] = 8'h00; pl[3] = 8'h0A;
    pl[4] = 8'h04; pl[5] = 8'h40; pl[6] = 8'h08; pl[7] = 8'h00;
    rst = 1'b1; start = 1'b0;
    bif.rx_valid = 1'b0; bif.rx_data = 8'h00;
    mem_instr = 32'h1234_5678;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state: program runs freely
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_rx_ready", 32'(bif.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bif.mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fetch", fetch_instr, 32'h1234_5678);

    // Good load, back-to-back bytes; 00+08+payload = 0xFE
    pulse_start();
    check("ld_hold", 32'(cpu_hold), 32'd1);
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_rx_ready", 32'(bif.rx_ready), 32'd1);
    check("ld_fetch_nop", fetch_instr, 32'h0);
    send_stream(0, 8'hFE);
    check("ld_done", 32'(done), 32'd1);
    check("ld_restart", 32'(cpu_restart), 32'd1);
    check("ld_hold_fall", 32'(cpu_hold), 32'd0);
    check("ld_busy_fall", 32'(busy), 32'd0);
    check("ld_err", 32'(err), 32'd0);
    @(negedge clk);
    check("ld_restart_pulse", 32'(cpu_restart), 32'd0);
    check("ld_restart_count", 32'(restart_n), 32'd1);
    check("ld_fetch_run", fetch_instr, 32'h1234_5678);
    check_writes("ld");
    check("ld_fetch_hold_nop", 32'(fetch_bad), 32'd0);

    // Same image with 3 idle cycles before every byte
    wr_a.delete(); wr_d.delete();
    pulse_start();
    check("gap_done_cleared", 32'(done), 32'd0);
    send_stream(3, 8'hFE);
    check("gap_done", 32'(done), 32'd1);
    check("gap_restart", 32'(cpu_restart), 32'd1);
    @(negedge clk);
    check_writes("gap");
    check("gap_restart_count", 32'(restart_n), 32'd2);

    // Bad headers: not word multiple, too large, empty
    bad_header("hdr6", 8'h00, 8'h06);
    bad_header("hdr1028", 8'h04, 8'h04);
    bad_header("hdr0", 8'h00, 8'h00);

    // Bad checksum: all writes happen, then ERR with pipeline held
    wr_a.delete(); wr_d.delete();
    pulse_start();
    check("cs_err_cleared", 32'(err), 32'd0);
    send_stream(0, 8'hFF);
    check("cs_err", 32'(err), 32'd1);
    check("cs_done", 32'(done), 32'd0);
    check("cs_hold", 32'(cpu_hold), 32'd1);
    check("cs_restart", 32'(cpu_restart), 32'd0);
    repeat (2) @(negedge clk);
    check("cs_hold_kept", 32'(cpu_hold), 32'd1);
    check("cs_fetch_nop", fetch_instr, 32'h0);
    check_writes("cs");

    // Recovery from ERR
    rn = restart_n;
    wr_a.delete(); wr_d.delete();
    pulse_start();
    send_stream(0, 8'hFE);
    check("rec_done", 32'(done), 32'd1);
    check("rec_err", 32'(err), 32'd0);
    @(negedge clk);
    check("rec_restart_count", 32'(restart_n), 32'(rn + 1));

    // start during LOAD ignored, then reset after 5 payload bytes
    wr_a.delete(); wr_d.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    for (int i = 0; i < 4; i++) send_byte(pl[i], 0);
    pulse_start();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_rx_ready", 32'(bif.rx_ready), 32'd1);
    send_byte(pl[4], 0);
    @(negedge clk);
    check("mid_wr_count", 32'(wr_a.size()), 32'd5);
    check("mid_waddr4", (wr_a.size() > 4) ? 32'(wr_a[4]) : 32'hFFFF_FFFF, 32'd4);
    check("mid_wdata4", (wr_d.size() > 4) ? 32'(wr_d[4]) : 32'hFFFF_FFFF, 32'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_hold", 32'(cpu_hold), 32'd0);
    check("mrst_rx_ready", 32'(bif.rx_ready), 32'd0);
    check("mrst_mem_we", 32'(bif.mem_we), 32'd0);
    check("mrst_waddr", 32'(bif.mem_waddr), 32'd0);
    check("mrst_wdata", 32'(bif.mem_wdata), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_restart", 32'(cpu_restart), 32'd0);
    check("mrst_fetch", fetch_instr, 32'h1234_5678);
    repeat (2) @(negedge clk);
    check("mrst_idle_ready", 32'(bif.rx_ready), 32'd0);
    check("mrst_no_more_writes", 32'(wr_a.size()), 32'd5);
    check("final_latency", 32'(lat_bad), 32'd0);
    check("final_fetch_hold_nop", 32'(fetch_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
